// File: rtl/mem_to_axi_initiator.sv
// rtl/mem_to_axi_initiator.sv - single-outstanding memory-port to AXI4 initiator bridge
package mem_to_axi_pkg;
    // Default AXI channel layouts, sized for the bridge's default parameters.
    typedef struct packed {
        logic [3:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [47:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [0:0]  user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        logic         b_valid;
        axi_b_chan_t  b;
        logic         r_valid;
        axi_r_chan_t  r;
    } axi_rsp_t;
endpackage

module mem_to_axi_initiator #(
    parameter int unsigned        AddrWidth = 48,
    parameter int unsigned        DataWidth = 64,
    parameter int unsigned        IdWidth   = 4,
    parameter logic [IdWidth-1:0] AxiId     = '0,
    parameter type                axi_req_t = mem_to_axi_pkg::axi_req_t,
    parameter type                axi_rsp_t = mem_to_axi_pkg::axi_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic                   mem_we_i,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_strb_i,
    output logic                   mem_rvalid_o,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   mem_err_o,
    output logic                   busy_o,
    output axi_req_t               axi_req_o,
    input  axi_rsp_t               axi_rsp_i
);
    localparam logic [2:0] Size = 3'($clog2(DataWidth / 8));

    typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, READ, RD_RESP} state_t;

    state_t                 r_state;
    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth-1:0]   r_wdata;
    logic [DataWidth/8-1:0] r_strb;
    logic                   r_aw_valid;
    logic                   r_w_valid;
    logic                   r_ar_valid;
    logic                   r_b_ready;
    logic                   r_r_ready;
    logic                   r_rvalid;
    logic [DataWidth-1:0]   r_rdata;
    logic                   r_err;

    logic w_gnt;
    logic w_aw_done;
    logic w_w_done;
    logic w_unused;

    assign w_gnt        = mem_req_i && (r_state == IDLE) && !rst_i;
    assign mem_gnt_o    = w_gnt;
    assign busy_o       = (r_state != IDLE);
    assign mem_rvalid_o = r_rvalid;
    assign mem_rdata_o  = r_rdata;
    assign mem_err_o    = r_err;

    // A channel counts as done once its handshake has happened, now or earlier.
    assign w_aw_done = !r_aw_valid || axi_rsp_i.aw_ready;
    assign w_w_done  = !r_w_valid  || axi_rsp_i.w_ready;

    // Response IDs, low resp bits, r.last and user fields carry no meaning here.
    assign w_unused = ^{axi_rsp_i.b.id, axi_rsp_i.b.resp[0], axi_rsp_i.b.user,
                        axi_rsp_i.r.id, axi_rsp_i.r.resp[0], axi_rsp_i.r.last,
                        axi_rsp_i.r.user};

    always_comb begin
        axi_req_o           = '0;
        axi_req_o.aw.id     = AxiId;
        axi_req_o.aw.addr   = r_addr;
        axi_req_o.aw.size   = Size;
        axi_req_o.aw.burst  = 2'b01;
        axi_req_o.aw_valid  = r_aw_valid;
        axi_req_o.w.data    = r_wdata;
        axi_req_o.w.strb    = r_strb;
        axi_req_o.w.last    = 1'b1;
        axi_req_o.w_valid   = r_w_valid;
        axi_req_o.b_ready   = r_b_ready;
        axi_req_o.ar.id     = AxiId;
        axi_req_o.ar.addr   = r_addr;
        axi_req_o.ar.size   = Size;
        axi_req_o.ar.burst  = 2'b01;
        axi_req_o.ar_valid  = r_ar_valid;
        axi_req_o.r_ready   = r_r_ready;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_b_ready  <= 1'b0;
            r_r_ready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_addr  <= mem_addr_i;
                        r_wdata <= mem_wdata_i;
                        r_strb  <= mem_strb_i;
                        if (mem_we_i) begin
                            r_state    <= WRITE;
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                        end else begin
                            r_state    <= READ;
                            r_ar_valid <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (axi_rsp_i.aw_ready) r_aw_valid <= 1'b0;
                    if (axi_rsp_i.w_ready)  r_w_valid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_state   <= WR_RESP;
                        r_b_ready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axi_rsp_i.b_valid) begin
                        r_state   <= IDLE;
                        r_b_ready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= '0;
                        r_err     <= axi_rsp_i.b.resp[1];
                    end
                end
                READ: begin
                    if (axi_rsp_i.ar_ready) begin
                        r_state    <= RD_RESP;
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (axi_rsp_i.r_valid) begin
                        r_state   <= IDLE;
                        r_r_ready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= axi_rsp_i.r.data;
                        r_err     <= axi_rsp_i.r.resp[1];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_to_axi_initiator.sv
// tb/tb_mem_to_axi_initiator.sv - bench for mem_to_axi_initiator
module tb_mem_to_axi_initiator;
    import mem_to_axi_pkg::*;

    localparam logic [3:0] AXI_ID = 4'h5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_gnt;
    logic        mem_we = 1'b0;
    logic [47:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [7:0]  mem_strb = '0;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        busy;
    axi_req_t    axi_req;
    axi_rsp_t    axi_rsp;

    always #5 clk = ~clk;

    mem_to_axi_initiator #(
        .AddrWidth(48), .DataWidth(64), .IdWidth(4), .AxiId(AXI_ID),
        .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst), .mem_req_i(mem_req), .mem_gnt_o(mem_gnt),
        .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_strb_i(mem_strb), .mem_rvalid_o(mem_rvalid), .mem_rdata_o(mem_rdata),
        .mem_err_o(mem_err), .busy_o(busy), .axi_req_o(axi_req), .axi_rsp_i(axi_rsp)
    );

    typedef struct { bit we; logic [47:0] addr; logic [63:0] data; logic [7:0] strb; } txn_t;
    typedef struct { logic [63:0] data; logic err; } exp_t;

    txn_t req_q[$];
    exp_t exp_q[$];
    int   grant_cyc[$];
    int   pulse_cyc[$];
    int   n_checks = 0, n_fail = 0;
    int   cycle = 0, grants = 0, pulses = 0, outstanding = 0;

    // Slave behaviour knobs
    bit          rand_dly = 0;
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          forced = 0;
    logic [1:0]  f_resp = 2'b00;
    logic [63:0] f_rdata = '0;
    int          aw_vcnt = 0, w_vcnt = 0;

    always @(posedge clk) cycle++;

    // Memory-side monitor: grant log, scoreboard compare, outstanding bound.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            if (mem_rvalid) begin
                pulses++;
                pulse_cyc.push_back(cycle);
                outstanding--;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: rvalid at cycle %0d with nothing pending", cycle);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (mem_rdata !== e.data || mem_err !== e.err) begin
                        n_fail++;
                        $display("FAIL rsp_data: got data=%h err=%b, want data=%h err=%b",
                                 mem_rdata, mem_err, e.data, e.err);
                    end
                end
            end
            if (mem_req && mem_gnt) begin
                txn_t t;
                t.we = mem_we; t.addr = mem_addr; t.data = mem_wdata; t.strb = mem_strb;
                req_q.push_back(t);
                grants++;
                grant_cyc.push_back(cycle);
                outstanding++;
                n_checks++;
                if (outstanding > 1) begin
                    n_fail++;
                    $display("FAIL outstanding: got %0d in flight, want at most 1", outstanding);
                end
            end
        end
    end

    function automatic txn_t next_req();
        txn_t t;
        t = '{we: 0, addr: '0, data: '0, strb: '0};
        n_checks++;
        if (req_q.size() == 0) begin
            n_fail++;
            $display("FAIL axi_unrequested: AXI activity with no granted request");
        end else t = req_q.pop_front();
        return t;
    endfunction

    task automatic slave_write();
        txn_t t;
        int ac = 0, wc = 0, bd, guard = 0;
        bit ad = 0, wd = 0, hs;
        logic [1:0] resp;
        t = next_req();
        n_checks++;
        if (t.we !== 1'b1 || axi_req.ar_valid !== 1'b0 || axi_req.b_ready !== 1'b0 || axi_req.r_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_start: got we=%b ar_v=%b b_rdy=%b r_rdy=%b, want 1 0 0 0",
                     t.we, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready);
        end
        if (rand_dly) begin
            aw_dly = $urandom_range(0, 8); w_dly = $urandom_range(0, 8); b_dly = $urandom_range(0, 8);
        end
        aw_vcnt = 0; w_vcnt = 0;
        while (!(ad && wd)) begin
            if (rst) begin axi_rsp.aw_ready = 0; axi_rsp.w_ready = 0; return; end
            if (axi_req.aw_valid) aw_vcnt++;
            if (axi_req.w_valid)  w_vcnt++;
            axi_rsp.aw_ready = !ad && axi_req.aw_valid && ac >= aw_dly;
            axi_rsp.w_ready  = !wd && axi_req.w_valid && wc >= w_dly;
            if (axi_rsp.aw_ready) begin
                n_checks++;
                if (axi_req.aw.addr !== t.addr || axi_req.aw.len !== 8'd0 || axi_req.aw.size !== 3'd3 ||
                    axi_req.aw.burst !== 2'b01 || axi_req.aw.id !== AXI_ID ||
                    {axi_req.aw.lock, axi_req.aw.cache, axi_req.aw.prot, axi_req.aw.qos,
                     axi_req.aw.region, axi_req.aw.atop, axi_req.aw.user} !== '0) begin
                    n_fail++;
                    $display("FAIL aw_payload: got addr=%h len=%0d size=%0d burst=%0d id=%h, want addr=%h len=0 size=3 burst=1 id=%h",
                             axi_req.aw.addr, axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst,
                             axi_req.aw.id, t.addr, AXI_ID);
                end
            end
            if (axi_rsp.w_ready) begin
                n_checks++;
                if (axi_req.w.data !== t.data || axi_req.w.strb !== t.strb || axi_req.w.last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL w_payload: got data=%h strb=%h last=%b, want data=%h strb=%h last=1",
                             axi_req.w.data, axi_req.w.strb, axi_req.w.last, t.data, t.strb);
                end
            end
            ac++; wc++;
            @(posedge clk);
            if (axi_rsp.aw_ready) ad = 1;
            if (axi_rsp.w_ready)  wd = 1;
            #1;
            axi_rsp.aw_ready = 0; axi_rsp.w_ready = 0;
            if (++guard > 100) begin
                n_checks++; n_fail++;
                $display("FAIL wr_handshake_timeout: aw_done=%b w_done=%b, want both 1", ad, wd);
                return;
            end
        end
        bd = b_dly;
        for (int i = 0; i < bd; i++) begin
            if (rst) return;
            @(posedge clk); #1;
        end
        if (rst) return;
        n_checks++;
        if (axi_req.aw_valid !== 1'b0 || axi_req.w_valid !== 1'b0 || axi_req.b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_resp_phase: got aw_v=%b w_v=%b b_rdy=%b, want 0 0 1",
                     axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready);
        end
        resp = forced ? f_resp : 2'($urandom);
        axi_rsp.b_valid = 1; axi_rsp.b.resp = resp; axi_rsp.b.id = 4'($urandom);
        guard = 0;
        forever begin
            if (rst) begin axi_rsp.b_valid = 0; return; end
            hs = axi_req.b_ready;
            @(posedge clk);
            if (hs) break;
            #1;
            if (++guard > 100) begin
                n_checks++; n_fail++;
                $display("FAIL b_timeout: b_ready=0, want 1");
                axi_rsp.b_valid = 0;
                return;
            end
        end
        exp_q.push_back('{data: 64'd0, err: resp[1]});
        #1 axi_rsp.b_valid = 0;
    endtask

    task automatic slave_read();
        txn_t t;
        int ac = 0, rd, guard = 0;
        bit hs;
        logic [1:0] resp;
        logic [63:0] data;
        t = next_req();
        n_checks++;
        if (t.we !== 1'b0 || axi_req.aw_valid !== 1'b0 || axi_req.b_ready !== 1'b0 || axi_req.r_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_start: got we=%b aw_v=%b b_rdy=%b r_rdy=%b, want 0 0 0 0",
                     t.we, axi_req.aw_valid, axi_req.b_ready, axi_req.r_ready);
        end
        if (rand_dly) begin ar_dly = $urandom_range(0, 8); r_dly = $urandom_range(0, 8); end
        forever begin
            if (rst) begin axi_rsp.ar_ready = 0; return; end
            axi_rsp.ar_ready = axi_req.ar_valid && ac >= ar_dly;
            if (axi_rsp.ar_ready) begin
                n_checks++;
                if (axi_req.ar.addr !== t.addr || axi_req.ar.len !== 8'd0 || axi_req.ar.size !== 3'd3 ||
                    axi_req.ar.burst !== 2'b01 || axi_req.ar.id !== AXI_ID) begin
                    n_fail++;
                    $display("FAIL ar_payload: got addr=%h len=%0d size=%0d burst=%0d id=%h, want addr=%h len=0 size=3 burst=1 id=%h",
                             axi_req.ar.addr, axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst,
                             axi_req.ar.id, t.addr, AXI_ID);
                end
            end
            hs = axi_rsp.ar_ready;
            ac++;
            @(posedge clk); #1;
            axi_rsp.ar_ready = 0;
            if (hs) break;
            if (++guard > 100) begin
                n_checks++; n_fail++;
                $display("FAIL ar_timeout: ar_valid never accepted");
                return;
            end
        end
        rd = r_dly;
        for (int i = 0; i < rd; i++) begin
            if (rst) return;
            @(posedge clk); #1;
        end
        if (rst) return;
        resp = forced ? f_resp : 2'($urandom);
        data = forced ? f_rdata : {$urandom, $urandom};
        axi_rsp.r_valid = 1; axi_rsp.r.resp = resp; axi_rsp.r.data = data;
        axi_rsp.r.id = 4'($urandom); axi_rsp.r.last = 1'($urandom);
        guard = 0;
        forever begin
            if (rst) begin axi_rsp.r_valid = 0; return; end
            hs = axi_req.r_ready;
            @(posedge clk);
            if (hs) break;
            #1;
            if (++guard > 100) begin
                n_checks++; n_fail++;
                $display("FAIL r_timeout: r_ready=0, want 1");
                axi_rsp.r_valid = 0;
                return;
            end
        end
        exp_q.push_back('{data: data, err: resp[1]});
        #1 axi_rsp.r_valid = 0;
    endtask

    // AXI subordinate model: serves one transaction at a time.
    initial begin
        axi_rsp = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst && (axi_req.aw_valid || axi_req.w_valid)) slave_write();
            else if (!rst && axi_req.ar_valid) slave_read();
        end
    end

    task automatic issue(input bit we, input logic [47:0] addr, input logic [63:0] data, input logic [7:0] strb);
        int g = 0;
        mem_req = 1; mem_we = we; mem_addr = addr; mem_wdata = data; mem_strb = strb;
        @(negedge clk);
        while (!mem_gnt) begin
            @(negedge clk);
            if (++g > 200) begin
                n_checks++; n_fail++;
                $display("FAIL grant_timeout: no grant for addr=%h", addr);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        mem_req = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int g = 0;
        while (outstanding != 0 || exp_q.size() != 0) begin
            @(negedge clk);
            if (++g > 500) begin
                n_checks++; n_fail++;
                $display("FAIL drain_timeout: outstanding=%0d pending=%0d, want 0 0", outstanding, exp_q.size());
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (mem_gnt !== 0 || mem_rvalid !== 0 || mem_err !== 0 || busy !== 0 || mem_rdata !== '0 ||
            axi_req.aw_valid !== 0 || axi_req.w_valid !== 0 || axi_req.ar_valid !== 0 ||
            axi_req.b_ready !== 0 || axi_req.r_ready !== 0) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b rv=%b err=%b busy=%b rdata=%h awv=%b wv=%b arv=%b brdy=%b rrdy=%b, want all 0",
                     tag, mem_gnt, mem_rvalid, mem_err, busy, mem_rdata, axi_req.aw_valid,
                     axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1; mem_req = 1; mem_we = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        mem_req = 0; rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        int p0 = pulses;
        rand_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; forced = 1; f_resp = 2'b00;
        issue(1, 48'h100, 64'hDEADBEEF, 8'hFF);
        idle(0);
        drain();
        n_checks++;
        if (pulses - p0 != 1 || pulse_cyc[$] - grant_cyc[$] != 3) begin
            n_fail++;
            $display("FAIL write_latency: got pulses=%0d latency=%0d, want 1 and 3",
                     pulses - p0, pulse_cyc[$] - grant_cyc[$]);
        end
    endtask

    task automatic test_aw_delay();
        int p0 = pulses;
        aw_dly = 3; w_dly = 0; b_dly = 0; f_resp = 2'b00;
        issue(1, 48'h240, 64'h1122334455667788, 8'h0F);
        idle(0);
        drain();
        n_checks++;
        if (aw_vcnt != 4 || w_vcnt != 1 || pulses - p0 != 1) begin
            n_fail++;
            $display("FAIL aw_delay: got aw_cycles=%0d w_cycles=%0d pulses=%0d, want 4 1 1",
                     aw_vcnt, w_vcnt, pulses - p0);
        end
        aw_dly = 0;
    endtask

    task automatic test_read_err();
        int p0 = pulses;
        f_resp = 2'b10; f_rdata = 64'h0123456789ABCDEF; ar_dly = 1; r_dly = 2;
        issue(0, 48'h2000, '0, '0);
        idle(0);
        drain();
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (pulses - p0 != 1 || pulse_cyc[$] - grant_cyc[$] != 6) begin
            n_fail++;
            $display("FAIL read_err: got pulses=%0d latency=%0d, want 1 and 6",
                     pulses - p0, pulse_cyc[$] - grant_cyc[$]);
        end
        ar_dly = 0; r_dly = 0; forced = 0;
    endtask

    task automatic test_back_to_back();
        int p0 = pulses, g0 = grants;
        issue(0, 48'h3000, '0, '0);
        issue(1, 48'h3008, 64'hCAFEF00D12345678, 8'hA5);
        idle(0);
        drain();
        n_checks++;
        if (pulses - p0 != 2 || grants - g0 != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got pulses=%0d grants=%0d, want 2 2", pulses - p0, grants - g0);
        end
        n_checks++;
        if (grant_cyc[$] != pulse_cyc[$-1]) begin
            n_fail++;
            $display("FAIL b2b_grant_cycle: got grant at %0d, want %0d", grant_cyc[$], pulse_cyc[$-1]);
        end
    endtask

    task automatic test_reset_mid();
        int p0, g = 0;
        b_dly = 50;
        issue(1, 48'h400, 64'h5555AAAA5555AAAA, 8'hFF);
        idle(0);
        while (!axi_req.b_ready) begin
            @(negedge clk);
            if (++g > 50) begin
                n_checks++; n_fail++;
                $display("FAIL reach_wr_resp: b_ready=0, want 1");
                break;
            end
        end
        @(negedge clk);
        p0 = pulses;
        rst = 1; mem_req = 1; mem_we = 0; mem_addr = 48'h500;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        @(posedge clk); #1;
        b_dly = 0; rst = 0; mem_req = 0;
        repeat (5) @(posedge clk); #1;
        n_checks++;
        if (pulses != p0) begin
            n_fail++;
            $display("FAIL reset_no_pulse: got %0d pulses, want 0", pulses - p0);
        end
        issue(0, 48'h500, '0, '0);
        idle(0);
        drain();
        n_checks++;
        if (pulses - p0 != 1) begin
            n_fail++;
            $display("FAIL reset_recover: got %0d pulses, want 1", pulses - p0);
        end
    endtask

    task automatic test_random();
        int p0 = pulses, g0 = grants;
        rand_dly = 1; forced = 0;
        for (int i = 0; i < 1000; i++) begin
            issue(1'($urandom), {16'($urandom), $urandom}, {$urandom, $urandom}, 8'($urandom));
            idle($urandom_range(0, 2));
        end
        idle(0);
        drain();
        rand_dly = 0;
        n_checks++;
        if (pulses - p0 != 1000 || grants - g0 != 1000 || req_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_totals: got pulses=%0d grants=%0d leftover=%0d, want 1000 1000 0",
                     pulses - p0, grants - g0, req_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_aw_delay();
        test_read_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
